// File: rtl/xosera_bus_frontend_pkg.sv
// Shared types for the Xosera host-bus front end.
// Bus FSM state encoding plus the active levels of the bus control pins.
package xosera_bus_frontend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      DELAY,
      ACK
   } bus_fsm_t;

   localparam logic CS_ENABLED = 1'b0;
   localparam logic RnW_READ   = 1'b1;

endpackage

// File: rtl/xosera_sync_ff.sv
// Generic multi-bit synchroniser: STAGES flops per bit, clears to RST_VAL.
// Ports: clk, reset_n_i (sync, active low), d_i (async in), q_o (synchronised out).
module xosera_sync_ff #(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_sync [STAGES];

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= RST_VAL;
         end
      end else begin
         r_sync[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/xosera_bus_frontend.sv
// Host-bus front end: syncs m68k-style bus pins, sequences each access,
// issues strobes/DTACK/output-enable, and holds core reset until PLL lock settles.
// Ports: bus_* pins in/out, rd/wr strobes + captured reg/data to core,
// pll_lock_i -> reset_o, reconfig/boot-select registered for warm boot.
module xosera_bus_frontend
   import xosera_bus_frontend_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int REG_BITS     = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int DTACK_DELAY  = 1,
   parameter int LOCK_HOLDOFF = 16,
   parameter int BOOT_BITS    = 2
) (
   input  logic                  clk,
   input  logic                  reset_n_i,
   input  logic                  pll_lock_i,
   input  logic                  bus_cs_n_i,
   input  logic                  bus_rd_nwr_i,
   input  logic                  bus_bytesel_i,
   input  logic [REG_BITS-1:0]   bus_reg_num_i,
   input  logic [DATA_WIDTH-1:0] bus_data_i,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   input  logic                  reconfig_i,
   input  logic [BOOT_BITS-1:0]  boot_select_i,
   output logic                  reset_o,
   output logic                  wr_strobe_o,
   output logic                  rd_strobe_o,
   output logic [REG_BITS-1:0]   reg_num_o,
   output logic                  bytesel_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic [DATA_WIDTH-1:0] bus_data_o,
   output logic                  bus_out_ena_o,
   output logic                  bus_dtack_n_o,
   output logic                  reconfig_o,
   output logic [BOOT_BITS-1:0]  boot_select_o
);

   localparam int CW = REG_BITS + 3;
   localparam logic [CW-1:0] CTL_RST = {1'b1, {(CW-1){1'b0}}};
   localparam int HW = $clog2(LOCK_HOLDOFF + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_HOLDOFF);
   // DELAY always lasts at least one cycle so read data can be latched
   localparam logic [3:0] DLY_LAST =
      (DTACK_DELAY == 0) ? 4'd0 : 4'(DTACK_DELAY - 1);

   logic [CW-1:0]         w_ctl_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic                  w_cs_n;
   logic                  w_rd;
   logic                  w_bs;
   logic [REG_BITS-1:0]   w_reg;
   logic [HW-1:0]         w_lock_nxt;
   logic                  w_hold;

   bus_fsm_t              r_state;
   logic [3:0]            r_dly_cnt;
   logic [HW-1:0]         r_lock_cnt;
   logic                  r_reset;
   logic                  r_rd;
   logic                  r_wr_strobe;
   logic                  r_rd_strobe;
   logic [REG_BITS-1:0]   r_reg_num;
   logic                  r_bytesel;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [DATA_WIDTH-1:0] r_bus_data;
   logic                  r_out_ena;
   logic                  r_dtack_n;
   logic                  r_reconfig;
   logic [BOOT_BITS-1:0]  r_boot_sel;

   xosera_sync_ff #(
      .WIDTH  (CW),
      .STAGES (SYNC_STAGES),
      .RST_VAL(CTL_RST)
   ) u_sync_ctl (
      .clk      (clk),
      .reset_n_i(reset_n_i),
      .d_i      ({bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i}),
      .q_o      (w_ctl_q)
   );

   xosera_sync_ff #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (SYNC_STAGES),
      .RST_VAL('0)
   ) u_sync_data (
      .clk      (clk),
      .reset_n_i(reset_n_i),
      .d_i      (bus_data_i),
      .q_o      (w_data_q)
   );

   assign {w_cs_n, w_rd, w_bs, w_reg} = w_ctl_q;

   always_comb begin
      w_lock_nxt = r_lock_cnt;
      if (!pll_lock_i) begin
         w_lock_nxt = '0;
      end else if (r_lock_cnt != HOLD_MAX) begin
         w_lock_nxt = r_lock_cnt + 1'b1;
      end
   end

   // Use next-state hold so a lock drop aborts the access on the same
   // edge reset_o rises (no DTACK can slip out behind it).
   assign w_hold = (w_lock_nxt != HOLD_MAX);

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         r_state     <= IDLE;
         r_dly_cnt   <= '0;
         r_lock_cnt  <= '0;
         r_reset     <= 1'b1;
         r_rd        <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_rd_strobe <= 1'b0;
         r_reg_num   <= '0;
         r_bytesel   <= 1'b0;
         r_wr_data   <= '0;
         r_bus_data  <= '0;
         r_out_ena   <= 1'b0;
         r_dtack_n   <= 1'b1;
         r_reconfig  <= 1'b0;
         r_boot_sel  <= '0;
      end else begin
         r_reconfig  <= reconfig_i;
         r_boot_sel  <= boot_select_i;
         r_lock_cnt  <= w_lock_nxt;
         r_reset     <= w_hold;
         r_wr_strobe <= 1'b0;
         r_rd_strobe <= 1'b0;
         if (w_hold) begin
            r_state   <= IDLE;
            r_out_ena <= 1'b0;
            r_dtack_n <= 1'b1;
         end else begin
            unique case (r_state)
               IDLE: begin
                  r_out_ena <= 1'b0;
                  r_dtack_n <= 1'b1;
                  if (w_cs_n == CS_ENABLED) begin
                     r_state <= SETUP;
                  end
               end
               SETUP: begin
                  r_reg_num <= w_reg;
                  r_bytesel <= w_bs;
                  r_rd      <= (w_rd == RnW_READ);
                  r_wr_data <= w_data_q;
                  if (w_cs_n != CS_ENABLED) begin
                     r_state <= IDLE;
                  end else begin
                     r_state     <= STROBE;
                     r_wr_strobe <= (w_rd != RnW_READ);
                     r_rd_strobe <= (w_rd == RnW_READ);
                  end
               end
               STROBE: begin
                  r_dly_cnt <= '0;
                  if (w_cs_n != CS_ENABLED) begin
                     r_state <= IDLE;
                  end else begin
                     r_state   <= DELAY;
                     r_out_ena <= r_rd;
                  end
               end
               DELAY: begin
                  if (w_cs_n != CS_ENABLED) begin
                     r_state   <= IDLE;
                     r_out_ena <= 1'b0;
                  end else begin
                     // core read data is valid only in the first DELAY cycle
                     if (r_rd && r_dly_cnt == 4'd0) begin
                        r_bus_data <= rd_data_i;
                     end
                     if (r_dly_cnt == DLY_LAST) begin
                        r_state   <= ACK;
                        r_dtack_n <= 1'b0;
                     end else begin
                        r_dly_cnt <= r_dly_cnt + 4'd1;
                     end
                  end
               end
               ACK: begin
                  if (w_cs_n != CS_ENABLED) begin
                     r_state   <= IDLE;
                     r_dtack_n <= 1'b1;
                     r_out_ena <= 1'b0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign reset_o       = r_reset;
   assign wr_strobe_o   = r_wr_strobe;
   assign rd_strobe_o   = r_rd_strobe;
   assign reg_num_o     = r_reg_num;
   assign bytesel_o     = r_bytesel;
   assign wr_data_o     = r_wr_data;
   assign bus_data_o    = r_bus_data;
   assign bus_out_ena_o = r_out_ena;
   assign bus_dtack_n_o = r_dtack_n;
   assign reconfig_o    = r_reconfig;
   assign boot_select_o = r_boot_sel;

endmodule

// File: tb/tb_xosera_bus_frontend.sv
// Scoreboard bench for xosera_bus_frontend.
// Bus accesses push expected strobes; a negedge monitor pops and checks them.
module tb_xosera_bus_frontend;

   logic       clk = 1'b0;
   logic       reset_n_i;
   logic       pll_lock_i;
   logic       bus_cs_n_i;
   logic       bus_rd_nwr_i;
   logic       bus_bytesel_i;
   logic [3:0] bus_reg_num_i;
   logic [7:0] bus_data_i;
   logic [7:0] rd_data_i;
   logic       reconfig_i;
   logic [1:0] boot_select_i;
   logic       reset_o;
   logic       wr_strobe_o;
   logic       rd_strobe_o;
   logic [3:0] reg_num_o;
   logic       bytesel_o;
   logic [7:0] wr_data_o;
   logic [7:0] bus_data_o;
   logic       bus_out_ena_o;
   logic       bus_dtack_n_o;
   logic       reconfig_o;
   logic [1:0] boot_select_o;

   always #5 clk = ~clk;

   xosera_bus_frontend #(
      .SYNC_STAGES (2),
      .REG_BITS    (4),
      .DATA_WIDTH  (8),
      .DTACK_DELAY (1),
      .LOCK_HOLDOFF(16),
      .BOOT_BITS   (2)
   ) dut (
      .clk          (clk),
      .reset_n_i    (reset_n_i),
      .pll_lock_i   (pll_lock_i),
      .bus_cs_n_i   (bus_cs_n_i),
      .bus_rd_nwr_i (bus_rd_nwr_i),
      .bus_bytesel_i(bus_bytesel_i),
      .bus_reg_num_i(bus_reg_num_i),
      .bus_data_i   (bus_data_i),
      .rd_data_i    (rd_data_i),
      .reconfig_i   (reconfig_i),
      .boot_select_i(boot_select_i),
      .reset_o      (reset_o),
      .wr_strobe_o  (wr_strobe_o),
      .rd_strobe_o  (rd_strobe_o),
      .reg_num_o    (reg_num_o),
      .bytesel_o    (bytesel_o),
      .wr_data_o    (wr_data_o),
      .bus_data_o   (bus_data_o),
      .bus_out_ena_o(bus_out_ena_o),
      .bus_dtack_n_o(bus_dtack_n_o),
      .reconfig_o   (reconfig_o),
      .boot_select_o(boot_select_o)
   );

   typedef struct packed {
      logic       rd;
      logic [3:0] rn;
      logic [7:0] d;
   } txn_t;

   txn_t sb[$];
   txn_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   n_strobe = 0;
   int   rd_phase = 0;
   logic [7:0] rd_pend_d;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Core model: rd_data_i valid only in the cycle after rd_strobe_o.
   always @(negedge clk) begin
      if (rd_phase == 1) begin
         rd_data_i = rd_pend_d;
         rd_phase = 2;
      end else if (rd_phase == 2) begin
         rd_data_i = 8'hEE;
         rd_phase = 0;
      end
      if (wr_strobe_o || rd_strobe_o) begin
         n_strobe++;
         chk("both_strobes", 32'(wr_strobe_o & rd_strobe_o), 0);
         chk("strobe_in_rst", 32'(reset_o), 0);
         if (sb.size() == 0) begin
            chk("unexp_strobe", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("strobe_kind", 32'(rd_strobe_o), 32'(mon_e.rd));
            chk("reg_num", 32'(reg_num_o), 32'(mon_e.rn));
            if (!mon_e.rd) begin
               chk("wr_data", 32'(wr_data_o), 32'(mon_e.d));
            end else begin
               rd_pend_d = mon_e.d;
               rd_phase = 1;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_lock(input string tag);
      int k = 0;
      while (reset_o && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(k), 16);
   endtask

   task automatic access(input logic rd, input logic [3:0] rn,
                         input logic [7:0] d);
      int  k = 0;
      int  ks = 0;
      logic got = 1'b0;
      bus_rd_nwr_i  = rd;
      bus_reg_num_i = rn;
      bus_bytesel_i = rn[0];
      bus_data_i    = rd ? 8'h00 : d;
      bus_cs_n_i    = 1'b0;
      sb.push_back('{rd: rd, rn: rn, d: d});
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if ((wr_strobe_o || rd_strobe_o) && ks == 0) ks = k;
         if (!bus_dtack_n_o) got = 1'b1;
      end
      chk("dtack_seen", 32'(got), 1);
      chk("strobe_lat", 32'(ks), 4);
      chk("dtack_lat", 32'(k), 6);
      chk("bytesel", 32'(bytesel_o), 32'(rn[0]));
      if (rd) chk("rd_bus_data", 32'(bus_data_o), 32'(d));
      chk("oe_in_ack", 32'(bus_out_ena_o), 32'(rd));
      cyc(1);
      chk("dtack_hold", 32'(bus_dtack_n_o), 0);
      bus_cs_n_i = 1'b1;
      cyc(2);
      chk("dtack_until_cs", 32'(bus_dtack_n_o), 0);
      chk("oe_until_cs", 32'(bus_out_ena_o), 32'(rd));
      cyc(1);
      chk("dtack_release", 32'(bus_dtack_n_o), 1);
      chk("oe_release", 32'(bus_out_ena_o), 0);
      cyc(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s0;
      int   k;
      logic saw;
      reset_n_i     = 1'b0;
      pll_lock_i    = 1'b0;
      bus_cs_n_i    = 1'b1;
      bus_rd_nwr_i  = 1'b1;
      bus_bytesel_i = 1'b0;
      bus_reg_num_i = '0;
      bus_data_i    = '0;
      rd_data_i     = 8'hEE;
      reconfig_i    = 1'b0;
      boot_select_i = '0;
      cyc(3);
      chk("rst_reset_o", 32'(reset_o), 1);
      chk("rst_dtack", 32'(bus_dtack_n_o), 1);
      chk("rst_oe", 32'(bus_out_ena_o), 0);
      chk("rst_strobes", 32'({wr_strobe_o, rd_strobe_o}), 0);
      chk("rst_reconfig", 32'(reconfig_o), 0);
      chk("rst_boot", 32'(boot_select_o), 0);
      chk("rst_reg", 32'(reg_num_o), 0);
      chk("rst_bus_data", 32'(bus_data_o), 0);

      reset_n_i     = 1'b1;
      reconfig_i    = 1'b1;
      boot_select_i = 2'd2;
      cyc(1);
      chk("reconfig_ungated", 32'(reconfig_o), 1);
      chk("boot_ungated", 32'(boot_select_o), 2);
      reconfig_i    = 1'b0;
      boot_select_i = 2'd1;
      cyc(1);
      chk("reconfig_follow", 32'(reconfig_o), 0);
      chk("boot_follow", 32'(boot_select_o), 1);
      cyc(4);
      chk("rst_no_lock", 32'(reset_o), 1);

      pll_lock_i = 1'b1;
      wait_lock("holdoff");
      pll_lock_i = 1'b0;
      cyc(1);
      chk("lock_drop", 32'(reset_o), 1);
      pll_lock_i = 1'b1;
      wait_lock("holdoff2");

      access(1'b0, 4'h3, 8'hA5);
      access(1'b1, 4'hC, 8'h5A);

      // one-cycle cs_n pulse: FSM reaches SETUP, then sees cs_n high
      s0 = n_strobe;
      bus_rd_nwr_i = 1'b0;
      bus_cs_n_i = 1'b0;
      cyc(1);
      bus_cs_n_i = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus_dtack_n_o) saw = 1'b1;
      end
      chk("glitch_dtack", 32'(saw), 0);
      chk("glitch_strobe", 32'(n_strobe - s0), 0);

      // PLL lock lost while in DELAY of a read
      bus_rd_nwr_i  = 1'b1;
      bus_reg_num_i = 4'h7;
      bus_bytesel_i = 1'b1;
      bus_cs_n_i    = 1'b0;
      sb.push_back('{rd: 1'b1, rn: 4'h7, d: 8'h33});
      cyc(5);
      chk("delay_oe", 32'(bus_out_ena_o), 1);
      pll_lock_i = 1'b0;
      cyc(1);
      chk("drop_reset_o", 32'(reset_o), 1);
      chk("drop_dtack", 32'(bus_dtack_n_o), 1);
      chk("drop_oe", 32'(bus_out_ena_o), 0);
      s0 = n_strobe;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!bus_dtack_n_o || bus_out_ena_o) saw = 1'b1;
      end
      chk("drop_quiet", 32'(saw), 0);
      chk("drop_no_strobe", 32'(n_strobe - s0), 0);
      bus_cs_n_i = 1'b1;
      cyc(3);
      pll_lock_i = 1'b1;
      wait_lock("holdoff3");

      // reset_n_i asserted while in ACK of a write
      bus_rd_nwr_i  = 1'b0;
      bus_reg_num_i = 4'h5;
      bus_bytesel_i = 1'b1;
      bus_data_i    = 8'h3C;
      bus_cs_n_i    = 1'b0;
      sb.push_back('{rd: 1'b0, rn: 4'h5, d: 8'h3C});
      k = 0;
      while (bus_dtack_n_o && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("ack2_lat", 32'(k), 6);
      reset_n_i = 1'b0;
      cyc(1);
      chk("mid_rst_dtack", 32'(bus_dtack_n_o), 1);
      chk("mid_rst_reset_o", 32'(reset_o), 1);
      chk("mid_rst_reg", 32'(reg_num_o), 0);
      chk("mid_rst_wdata", 32'(wr_data_o), 0);
      chk("mid_rst_bytesel", 32'(bytesel_o), 0);
      chk("mid_rst_bus_data", 32'(bus_data_o), 0);
      chk("mid_rst_boot", 32'(boot_select_o), 0);
      bus_cs_n_i = 1'b1;
      reset_n_i = 1'b1;
      wait_lock("holdoff4");

      access(1'b0, 4'h9, 8'h81);
      access(1'b1, 4'h2, 8'hC3);

      chk("sb_empty", 32'(sb.size()), 0);
      chk("strobe_count", 32'(n_strobe), 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
